lcd_bus_decoder: RTL and testbench

Receive-side model of the 8-bit LCD command/data bus driven by the display command generator. It watches byte strobes qualified by `dcx`, decodes the controller command set (SWRESET, SLPIN/SLPOUT, DISPOFF/DISPON, CASET, PASET, RAMWR), and tracks the column/page window and display state. It emits one pixel-write event per two RAMWR data bytes, carrying the walked (x, y) address. It is used as the bench-side display model and as an on-chip bus monitor for self-check.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/lcd_bus_decoder_if.sv | 12 +
 rtl/lcd_win_walker.sv | 47 ++++
 rtl/lcd_bus_decoder.sv | 195 +++++++++++++++++++
 tb/tb_lcd_bus_decoder.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared opcodes, widths and parser state encoding for the LCD bus decoder.
package lcd_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    localparam logic [BYTE_W-1:0] CMD_SWRESET = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_SLPIN   = 8'h10;
    localparam logic [BYTE_W-1:0] CMD_SLPOUT  = 8'h11;
    localparam logic [BYTE_W-1:0] CMD_DISPOFF = 8'h28;
    localparam logic [BYTE_W-1:0] CMD_DISPON  = 8'h29;
    localparam logic [BYTE_W-1:0] CMD_CASET   = 8'h2A;
    localparam logic [BYTE_W-1:0] CMD_PASET   = 8'h2B;
    localparam logic [BYTE_W-1:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_ARG,
        ST_PASET_ARG,
        ST_RAMWR_LO,
        ST_RAMWR_HI
    } lcd_rx_state_t;

endpackage

// File: rtl/lcd_bus_decoder_if.sv
// 8-bit command/data bus as seen between the command generator and the decoder.
interface lcd_bus_decoder_if;
    import lcd_pkg::*;

    logic              wr;
    logic [BYTE_W-1:0] d;
    logic              dcx;

    modport master (output wr, d, dcx);
    modport slave  (input  wr, d, dcx);

endinterface

// File: rtl/lcd_win_walker.sv
// Owns the RAMWR pixel pointer and walks it through the SC..EC / SP..EP window.
module lcd_win_walker
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [WORD_W-1:0] i_sc,
    input  logic [WORD_W-1:0] i_ec,
    input  logic [WORD_W-1:0] i_sp,
    input  logic [WORD_W-1:0] i_ep,
    output logic [WORD_W-1:0] o_x,
    output logic [WORD_W-1:0] o_y,
    output logic              o_last_c
);

    logic [WORD_W-1:0] r_x;
    logic [WORD_W-1:0] r_y;
    logic              w_row_end;
    logic              w_col_end;

    // A reversed window (end < start) makes every position an end position.
    assign w_row_end = (r_x >= i_ec);
    assign w_col_end = (r_y >= i_ep);
    assign o_last_c  = w_row_end && w_col_end;
    assign o_x       = r_x;
    assign o_y       = r_y;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_load) begin
            r_x <= i_sc;
            r_y <= i_sp;
        end else if (i_step) begin
            if (w_row_end) begin
                r_x <= i_sc;
                r_y <= w_col_end ? i_sp : r_y + 16'd1;
            end else begin
                r_x <= r_x + 16'd1;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_decoder.sv
// Receive-side LCD bus model: decodes commands, tracks window/display state
// and emits one pixel-write event per two RAMWR data bytes.
module lcd_bus_decoder
    import lcd_pkg::*;
#(
    parameter int unsigned WIDTH          = 240,
    parameter int unsigned HEIGHT         = 320,
    parameter bit          LOW_BYTE_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               nrst,
    lcd_bus_decoder_if.slave   bus,
    output logic               o_pix_valid,
    output logic [WORD_W-1:0]  o_pix_x,
    output logic [WORD_W-1:0]  o_pix_y,
    output logic [WORD_W-1:0]  o_pix_color,
    output logic [WORD_W-1:0]  o_sc,
    output logic [WORD_W-1:0]  o_ec,
    output logic [WORD_W-1:0]  o_sp,
    output logic [WORD_W-1:0]  o_ep,
    output logic               o_disp_on,
    output logic               o_sleep_out,
    output logic               o_frame_done,
    output logic               o_cmd_err
);

    localparam logic [WORD_W-1:0] EC_RST = WORD_W'(WIDTH - 1);
    localparam logic [WORD_W-1:0] EP_RST = WORD_W'(HEIGHT - 1);

    lcd_rx_state_t       r_state, w_state;
    logic [1:0]          r_arg_idx, w_arg_idx;
    logic [23:0]         r_arg_buf, w_arg_buf;
    logic [BYTE_W-1:0]   r_lo_byte, w_lo_byte;
    logic [WORD_W-1:0]   r_sc, w_sc, r_ec, w_ec, r_sp, w_sp, r_ep, w_ep;
    logic                r_disp_on, w_disp_on, r_sleep_out, w_sleep_out;
    logic                r_pix_valid, w_pix_valid, r_frame_done, w_frame_done;
    logic                r_cmd_err, w_cmd_err;
    logic [WORD_W-1:0]   r_pix_x, w_pix_x, r_pix_y, w_pix_y, r_pix_color, w_pix_color;

    logic                w_load, w_step, w_last;
    logic [WORD_W-1:0]   w_x, w_y;

    lcd_win_walker u_walker (
        .clk      (clk),
        .nrst     (nrst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_sc     (r_sc),
        .i_ec     (r_ec),
        .i_sp     (r_sp),
        .i_ep     (r_ep),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_last_c (w_last)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_arg_idx    <= '0;
            r_arg_buf    <= '0;
            r_lo_byte    <= '0;
            r_sc         <= '0;
            r_ec         <= EC_RST;
            r_sp         <= '0;
            r_ep         <= EP_RST;
            r_disp_on    <= 1'b0;
            r_sleep_out  <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_color  <= '0;
        end else begin
            r_state      <= w_state;
            r_arg_idx    <= w_arg_idx;
            r_arg_buf    <= w_arg_buf;
            r_lo_byte    <= w_lo_byte;
            r_sc         <= w_sc;
            r_ec         <= w_ec;
            r_sp         <= w_sp;
            r_ep         <= w_ep;
            r_disp_on    <= w_disp_on;
            r_sleep_out  <= w_sleep_out;
            r_pix_valid  <= w_pix_valid;
            r_frame_done <= w_frame_done;
            r_cmd_err    <= w_cmd_err;
            r_pix_x      <= w_pix_x;
            r_pix_y      <= w_pix_y;
            r_pix_color  <= w_pix_color;
        end
    end

    // Commands abort whatever is in progress; data bytes advance the current state.
    always_comb begin
        w_state      = r_state;
        w_arg_idx    = r_arg_idx;
        w_arg_buf    = r_arg_buf;
        w_lo_byte    = r_lo_byte;
        w_sc         = r_sc;
        w_ec         = r_ec;
        w_sp         = r_sp;
        w_ep         = r_ep;
        w_disp_on    = r_disp_on;
        w_sleep_out  = r_sleep_out;
        w_pix_valid  = 1'b0;
        w_frame_done = 1'b0;
        w_cmd_err    = 1'b0;
        w_pix_x      = r_pix_x;
        w_pix_y      = r_pix_y;
        w_pix_color  = r_pix_color;
        w_load       = 1'b0;
        w_step       = 1'b0;

        if (bus.wr && !bus.dcx) begin
            w_state = ST_IDLE;
            case (bus.d)
                CMD_SWRESET: begin
                    w_sc        = '0;
                    w_ec        = EC_RST;
                    w_sp        = '0;
                    w_ep        = EP_RST;
                    w_disp_on   = 1'b0;
                    w_sleep_out = 1'b0;
                end
                CMD_SLPIN:   w_sleep_out = 1'b0;
                CMD_SLPOUT:  w_sleep_out = 1'b1;
                CMD_DISPOFF: w_disp_on   = 1'b0;
                CMD_DISPON:  w_disp_on   = 1'b1;
                CMD_CASET: begin
                    w_state   = ST_CASET_ARG;
                    w_arg_idx = '0;
                end
                CMD_PASET: begin
                    w_state   = ST_PASET_ARG;
                    w_arg_idx = '0;
                end
                CMD_RAMWR: begin
                    w_load  = 1'b1;
                    w_state = ST_RAMWR_LO;
                end
                default:     w_cmd_err = 1'b1;
            endcase
        end else if (bus.wr) begin
            case (r_state)
                ST_IDLE: w_cmd_err = 1'b1;
                ST_CASET_ARG, ST_PASET_ARG: begin
                    // First three argument bytes are buffered so the pair commits atomically.
                    if (r_arg_idx == 2'd3) begin
                        if (r_state == ST_CASET_ARG) begin
                            w_sc = r_arg_buf[23:8];
                            w_ec = {r_arg_buf[7:0], bus.d};
                        end else begin
                            w_sp = r_arg_buf[23:8];
                            w_ep = {r_arg_buf[7:0], bus.d};
                        end
                        w_state = ST_IDLE;
                    end else begin
                        w_arg_buf = {r_arg_buf[15:0], bus.d};
                        w_arg_idx = r_arg_idx + 2'd1;
                    end
                end
                ST_RAMWR_LO: begin
                    w_lo_byte = bus.d;
                    w_state   = ST_RAMWR_HI;
                end
                ST_RAMWR_HI: begin
                    w_pix_valid  = 1'b1;
                    w_frame_done = w_last;
                    w_pix_x      = w_x;
                    w_pix_y      = w_y;
                    w_pix_color  = LOW_BYTE_FIRST ? {bus.d, r_lo_byte} : {r_lo_byte, bus.d};
                    w_step       = 1'b1;
                    w_state      = ST_RAMWR_LO;
                end
                default: w_state = ST_IDLE;
            endcase
        end
    end

    assign o_pix_valid  = r_pix_valid;
    assign o_pix_x      = r_pix_x;
    assign o_pix_y      = r_pix_y;
    assign o_pix_color  = r_pix_color;
    assign o_sc         = r_sc;
    assign o_ec         = r_ec;
    assign o_sp         = r_sp;
    assign o_ep         = r_ep;
    assign o_disp_on    = r_disp_on;
    assign o_sleep_out  = r_sleep_out;
    assign o_frame_done = r_frame_done;
    assign o_cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: directed scenarios plus random command/data traffic
// checked every cycle against a behavioural display-controller model.
module tb_lcd_bus_decoder;
    import lcd_pkg::*;

    localparam int unsigned WIDTH  = 240;
    localparam int unsigned HEIGHT = 320;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    lcd_bus_decoder_if bus ();

    logic        o_pix_valid, o_disp_on, o_sleep_out, o_frame_done, o_cmd_err;
    logic [15:0] o_pix_x, o_pix_y, o_pix_color, o_sc, o_ec, o_sp, o_ep;

    lcd_bus_decoder #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .LOW_BYTE_FIRST(1'b1)) u_dut (
        .clk(clk), .nrst(nrst), .bus(bus),
        .o_pix_valid(o_pix_valid), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y),
        .o_pix_color(o_pix_color), .o_sc(o_sc), .o_ec(o_ec), .o_sp(o_sp), .o_ep(o_ep),
        .o_disp_on(o_disp_on), .o_sleep_out(o_sleep_out),
        .o_frame_done(o_frame_done), .o_cmd_err(o_cmd_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: what the controller expects next, plus the observable register values.
    localparam int M_IDLE = 0, M_COLARG = 1, M_PAGEARG = 2, M_PIX1 = 3, M_PIX2 = 4;
    int m_mode, m_nargs, m_first, m_x, m_y;
    int m_args[4];
    int e_sc, e_ec, e_sp, e_ep, e_disp, e_sleep;
    int e_pv, e_fd, e_err, e_px, e_py, e_col;

    int px_q[$], py_q[$], fd_q[$], col_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_nargs = 0; m_first = 0; m_x = 0; m_y = 0;
        e_sc = 0; e_ec = WIDTH - 1; e_sp = 0; e_ep = HEIGHT - 1;
        e_disp = 0; e_sleep = 0;
        e_pv = 0; e_fd = 0; e_err = 0; e_px = 0; e_py = 0; e_col = 0;
    endtask

    task automatic model_strobe(input bit is_data, input int b);
        if (!is_data) begin
            m_mode = M_IDLE;
            case (b)
                8'h01: begin
                    e_sc = 0; e_ec = WIDTH - 1; e_sp = 0; e_ep = HEIGHT - 1;
                    e_disp = 0; e_sleep = 0;
                end
                8'h10: e_sleep = 0;
                8'h11: e_sleep = 1;
                8'h28: e_disp = 0;
                8'h29: e_disp = 1;
                8'h2A: begin m_mode = M_COLARG;  m_nargs = 0; end
                8'h2B: begin m_mode = M_PAGEARG; m_nargs = 0; end
                8'h2C: begin m_mode = M_PIX1; m_x = e_sc; m_y = e_sp; end
                default: e_err = 1;
            endcase
        end else begin
            case (m_mode)
                M_COLARG, M_PAGEARG: begin
                    m_args[m_nargs] = b;
                    m_nargs++;
                    if (m_nargs == 4) begin
                        if (m_mode == M_COLARG) begin
                            e_sc = m_args[0] * 256 + m_args[1];
                            e_ec = m_args[2] * 256 + m_args[3];
                        end else begin
                            e_sp = m_args[0] * 256 + m_args[1];
                            e_ep = m_args[2] * 256 + m_args[3];
                        end
                        m_mode = M_IDLE;
                    end
                end
                M_PIX1: begin m_first = b; m_mode = M_PIX2; end
                M_PIX2: begin
                    e_pv = 1; e_px = m_x; e_py = m_y;
                    e_col = b * 256 + m_first;
                    // Raster order: end of row wraps to next row, end of window wraps to origin.
                    if (m_x >= e_ec) begin
                        m_x = e_sc;
                        if (m_y >= e_ep) begin
                            m_y = e_sp; e_fd = 1;
                        end else begin
                            m_y = (m_y + 1) % 65536;
                        end
                    end else begin
                        m_x = m_x + 1;
                    end
                    m_mode = M_PIX1;
                end
                default: e_err = 1;
            endcase
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".pix_valid"},  32'(o_pix_valid),  e_pv);
        chk({ph, ".frame_done"}, 32'(o_frame_done), e_fd);
        chk({ph, ".cmd_err"},    32'(o_cmd_err),    e_err);
        chk({ph, ".pix_x"},      32'(o_pix_x),      e_px);
        chk({ph, ".pix_y"},      32'(o_pix_y),      e_py);
        chk({ph, ".pix_color"},  32'(o_pix_color),  e_col);
        chk({ph, ".sc"},         32'(o_sc),         e_sc);
        chk({ph, ".ec"},         32'(o_ec),         e_ec);
        chk({ph, ".sp"},         32'(o_sp),         e_sp);
        chk({ph, ".ep"},         32'(o_ep),         e_ep);
        chk({ph, ".disp_on"},    32'(o_disp_on),    e_disp);
        chk({ph, ".sleep_out"},  32'(o_sleep_out),  e_sleep);
    endtask

    task automatic cycle(input bit w, input bit is_data, input int b, input string ph);
        @(negedge clk);
        bus.wr = w; bus.dcx = is_data; bus.d = 8'(b);
        e_pv = 0; e_fd = 0; e_err = 0;
        if (w) model_strobe(is_data, b);
        @(posedge clk);
        #1;
        check_all(ph);
        if (o_pix_valid) begin
            px_q.push_back(int'(o_pix_x)); py_q.push_back(int'(o_pix_y));
            fd_q.push_back(int'(o_frame_done)); col_q.push_back(int'(o_pix_color));
        end
    endtask

    task automatic cmd(input int b, input string ph);  cycle(1'b1, 1'b0, b, ph); endtask
    task automatic dat(input int b, input string ph);  cycle(1'b1, 1'b1, b, ph); endtask
    task automatic idle(input int n, input string ph);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, ph);
    endtask

    task automatic clear_log();
        px_q.delete(); py_q.delete(); fd_q.delete(); col_q.delete();
    endtask

    initial begin
        int fd_cnt;
        bus.wr = 1'b0; bus.dcx = 1'b0; bus.d = '0;
        nrst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.ec_const", 32'(o_ec), 239);
        chk("reset.ep_const", 32'(o_ep), 319);
        @(negedge clk);
        nrst = 1'b1;
        idle(2, "post_reset");

        // Display on, stray byte
        cmd(8'h01, "swreset");
        cmd(8'h29, "dispon");
        chk("dispon.flag", 32'(o_disp_on), 1);
        dat(8'h55, "stray");
        chk("stray.err", 32'(o_cmd_err), 1);
        idle(1, "stray_after");

        // Window 20..40 x 0..20 and a single pixel
        clear_log();
        cmd(8'h2A, "caset"); dat(0, "caset"); dat(8'h14, "caset"); dat(0, "caset"); dat(8'h28, "caset");
        cmd(8'h2B, "paset"); dat(0, "paset"); dat(0, "paset"); dat(0, "paset"); dat(8'h14, "paset");
        cmd(8'h2C, "ramwr"); dat(8'h1E, "pix1"); dat(8'h90, "pix1");
        chk("pix1.count", px_q.size(), 1);
        if (px_q.size() == 1) begin
            chk("pix1.x", px_q[0], 20); chk("pix1.y", py_q[0], 0); chk("pix1.color", col_q[0], 16'h901E);
        end

        // Full frame walk plus one wrap pixel, back-to-back
        clear_log();
        cmd(8'h2C, "frame");
        for (int i = 0; i < 442; i++) begin
            dat(int'($urandom_range(0, 255)), "frame");
            dat(int'($urandom_range(0, 255)), "frame");
        end
        chk("frame.count", px_q.size(), 442);
        if (px_q.size() == 442) begin
            chk("frame.p21x", px_q[20], 40);  chk("frame.p21y", py_q[20], 0);
            chk("frame.p22x", px_q[21], 20);  chk("frame.p22y", py_q[21], 1);
            chk("frame.p441x", px_q[440], 40); chk("frame.p441y", py_q[440], 20);
            chk("frame.p441fd", fd_q[440], 1);
            chk("frame.p442x", px_q[441], 20); chk("frame.p442y", py_q[441], 0);
        end
        fd_cnt = 0;
        foreach (fd_q[i]) fd_cnt += fd_q[i];
        chk("frame.fd_count", fd_cnt, 1);

        // Aborted CASET leaves window alone
        cmd(8'h2A, "abort"); dat(0, "abort"); dat(8'h50, "abort");
        cmd(8'h2B, "abort"); dat(0, "abort"); dat(0, "abort"); dat(0, "abort"); dat(8'h14, "abort");
        chk("abort.sc", 32'(o_sc), 20); chk("abort.ec", 32'(o_ec), 40);

        // Held byte discarded by DISPOFF
        clear_log();
        cmd(8'h2C, "half"); dat(8'h12, "half"); cmd(8'h28, "half");
        chk("half.nopix", px_q.size(), 0);
        chk("half.disp", 32'(o_disp_on), 0);
        cmd(8'h2C, "half2"); dat(8'hFF, "half2"); dat(8'h00, "half2");
        chk("half2.count", px_q.size(), 1);
        if (px_q.size() == 1) begin
            chk("half2.color", col_q[0], 16'h00FF);
            chk("half2.x", px_q[0], 20); chk("half2.y", py_q[0], 0);
        end

        // Reset while holding the first pixel byte
        cmd(8'h2C, "rst_mid"); dat(8'h34, "rst_mid");
        @(negedge clk);
        bus.wr = 1'b0;
        nrst = 1'b0;
        model_reset();
        #1;
        check_all("rst_mid.async");
        @(negedge clk);
        nrst = 1'b1;
        idle(1, "rst_release");
        dat(8'hAA, "rst_idle_data");
        chk("rst_idle_data.err", 32'(o_cmd_err), 1);

        // Random traffic with small, sometimes reversed windows
        for (int op = 0; op < 400; op++) begin
            int k;
            k = int'($urandom_range(0, 99));
            if (k < 15) begin
                cmd(($urandom_range(0, 1) != 0) ? 8'h2A : 8'h2B, "rnd_win");
                for (int a = 0; a < 4; a++)
                    dat(((a % 2) == 0) ? (($urandom_range(0, 9) == 0) ? 1 : 0)
                                       : int'($urandom_range(0, 7)), "rnd_win");
            end else if (k < 50) begin
                cmd(8'h2C, "rnd_pix");
                for (int p = int'($urandom_range(1, 60)); p > 0; p--) dat(int'($urandom_range(0, 255)), "rnd_pix");
            end else if (k < 65) begin
                int opc[10] = '{8'h01, 8'h10, 8'h11, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h00, 8'hFF};
                cmd(opc[$urandom_range(0, 9)], "rnd_cmd");
            end else if (k < 75) begin
                dat(int'($urandom_range(0, 255)), "rnd_dat");
            end else if (k < 85) begin
                cmd(8'h2A, "rnd_part");
                for (int a = int'($urandom_range(0, 3)); a > 0; a--) dat(int'($urandom_range(0, 255)), "rnd_part");
            end else begin
                idle(int'($urandom_range(1, 4)), "rnd_idle");
            end
        end
        idle(2, "tail");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
